// File: rtl/core_column_readout.sv
// Core column readout: walks the CBA core column token chain for one
// trigger ID per request, buffers hit words and closes each event with a
// trailer word carrying the overflow flag, hit count and trigger ID.
module core_column_readout #(
  parameter int unsigned DATA_W     = 22,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SETTLE     = 2,
  parameter int unsigned MAX_HITS   = 64
) (
  input  logic              Clk,
  input  logic              ResetB,
  input  logic              ReqValid,
  input  logic [4:0]        ReqTrigId,
  output logic              ReqReady,
  output logic [4:0]        CoreTrigIdReq,
  output logic              CoreRead,
  input  logic              CoreToken,
  input  logic [DATA_W-1:0] CoreData,
  output logic [DATA_W:0]   OutData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              Busy
);

  localparam int unsigned WORD_W = DATA_W + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned HIT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE_W, S_CHECK, S_READ, S_CAPTURE, S_TRAILER
  } state_e;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [HIT_W-1:0]   hit_q, hit_d;
  logic               ovf_q, ovf_d;
  logic [4:0]         trig_id_q, trig_id_d;
  logic               core_read_q, core_read_d;
  logic               req_ready_q, req_ready_d;
  logic               busy_q, busy_d;

  logic [WORD_W-1:0]  mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WORD_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic [CNT_W-1:0]   free_c;
  logic               push_c;
  logic               pop_c;
  logic [WORD_W-1:0]  push_word_c;
  logic [WORD_W-1:0]  trailer_c;

  // Readout sequencer: next state, event bookkeeping and FIFO push request.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    hit_d       = hit_q;
    ovf_d       = ovf_q;
    trig_id_d   = trig_id_q;
    push_c      = 1'b0;
    push_word_c = '0;
    free_c      = CNT_W'(FIFO_DEPTH) - count_q;

    trailer_c        = '0;
    trailer_c[DATA_W] = 1'b1;
    trailer_c[13]    = ovf_q;
    trailer_c[12:5]  = hit_q;
    trailer_c[4:0]   = trig_id_q;

    case (state_q)
      S_IDLE: begin
        if (ReqValid) begin
          trig_id_d = ReqTrigId;
          hit_d     = '0;
          settle_d  = '0;
          state_d   = S_SETTLE_W;
        end
      end
      S_SETTLE_W: begin
        if (settle_q == SET_W'(SETTLE - 1)) begin
          settle_d = '0;
          state_d  = S_CHECK;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_CHECK: begin
        // Closing the event needs one slot for the trailer; a read needs two
        // so the trailer that follows the captured word always fits.
        if (!CoreToken || (hit_q == HIT_W'(MAX_HITS))) begin
          if (free_c != '0) begin
            ovf_d   = CoreToken;
            state_d = S_TRAILER;
          end
        end else if (free_c >= CNT_W'(2)) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        push_c      = 1'b1;
        push_word_c = {1'b0, CoreData};
        hit_d       = hit_q + HIT_W'(1);
        settle_d    = '0;
        state_d     = S_SETTLE_W;
      end
      S_TRAILER: begin
        push_c      = 1'b1;
        push_word_c = trailer_c;
        ovf_d       = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    core_read_d = (state_d == S_READ);
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // Output FIFO: storage, pointers, occupancy and registered head.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_c    = out_valid_q && OutReady;

    if (push_c) begin
      mem_d[wr_ptr_q] = push_word_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    out_valid_d = (count_d != '0);
    out_data_d  = mem_d[rd_ptr_d];
  end

  // State and FIFO registers.
  always_ff @(posedge Clk or negedge ResetB) begin
    if (!ResetB) begin
      state_q     <= S_IDLE;
      settle_q    <= '0;
      hit_q       <= '0;
      ovf_q       <= 1'b0;
      trig_id_q   <= '0;
      core_read_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      hit_q       <= hit_d;
      ovf_q       <= ovf_d;
      trig_id_q   <= trig_id_d;
      core_read_q <= core_read_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ReqReady      = req_ready_q;
  assign CoreTrigIdReq = trig_id_q;
  assign CoreRead      = core_read_q;
  assign OutData       = out_data_q;
  assign OutValid      = out_valid_q;
  assign Busy          = busy_q;

endmodule

// File: tb/tb_core_column_readout.sv
// Bench for core_column_readout: behavioural core column, event-level
// expected-word model and a per-cycle scoreboard, plus directed scenarios.
module tb_core_column_readout;

  localparam int unsigned DATA_W     = 22;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned SETTLE     = 2;
  localparam int unsigned MAX_HITS   = 12;

  logic              Clk;
  logic              ResetB;
  logic              ReqValid;
  logic [4:0]        ReqTrigId;
  logic              ReqReady;
  logic [4:0]        CoreTrigIdReq;
  logic              CoreRead;
  logic              CoreToken;
  logic [DATA_W-1:0] CoreData;
  logic [DATA_W:0]   OutData;
  logic              OutValid;
  logic              OutReady;
  logic              Busy;

  core_column_readout #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .SETTLE(SETTLE), .MAX_HITS(MAX_HITS)
  ) dut (
    .Clk(Clk), .ResetB(ResetB), .ReqValid(ReqValid), .ReqTrigId(ReqTrigId),
    .ReqReady(ReqReady), .CoreTrigIdReq(CoreTrigIdReq), .CoreRead(CoreRead),
    .CoreToken(CoreToken), .CoreData(CoreData), .OutData(OutData),
    .OutValid(OutValid), .OutReady(OutReady), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Event description written by the stimulus, consumed by the model.
  int         ev_seq = 0;
  logic [4:0] ev_id = '0;
  int         core_n = 0;
  int         core_base = 0;
  int         req_cyc = 0;

  // Model state owned by the negedge process.
  int              ncyc = 0;
  int              seen_seq = 0;
  int              core_idx = 0;
  int              reads_ev = 0;
  int              read_cyc [$];
  logic [DATA_W:0] exp_q [$];
  logic [DATA_W:0] seen [$];

  task automatic chk1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Core column model, expected-word model and scoreboard, mid-cycle.
  always @(negedge Clk) begin
    int n;
    int ovf;
    logic [DATA_W:0] w;
    logic [DATA_W:0] e;
    ncyc++;
    if (!ResetB) begin
      exp_q.delete();
      core_idx  = 0;
      seen_seq  = ev_seq;
      CoreToken = 1'b0;
    end else begin
      if (ev_seq != seen_seq) begin
        seen_seq = ev_seq;
        core_idx = 0;
        reads_ev = 0;
        read_cyc.delete();
        n   = (core_n > int'(MAX_HITS)) ? int'(MAX_HITS) : core_n;
        ovf = (core_n > int'(MAX_HITS)) ? 1 : 0;
        for (int i = 0; i < n; i++) begin
          w = (DATA_W+1)'(core_base + i);
          exp_q.push_back(w);
        end
        w = (DATA_W+1)'((1 << DATA_W) + (ovf << 13) + (n << 5) + int'(ev_id));
        exp_q.push_back(w);
      end

      if (OutValid && exp_q.size() == 0) begin
        chk1("unexpected_out_valid", OutValid, 1'b0);
      end else if (OutValid && OutReady) begin
        e = exp_q.pop_front();
        chkw("out_word", 64'(OutData), 64'(e));
        seen.push_back(OutData);
      end

      if (Busy) chkw("trig_id_stable", 64'(CoreTrigIdReq), 64'(ev_id));

      if (CoreRead) begin
        reads_ev++;
        read_cyc.push_back(ncyc);
        CoreData = DATA_W'(core_base + core_idx);
        core_idx++;
      end
      CoreToken = (core_idx < core_n);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_req(input logic [4:0] id, input int n, input int base);
    for (int i = 0; i < 400 && !ReqReady; i++) step();
    chk1("req_ready_before_req", ReqReady, 1'b1);
    ev_id     = id;
    core_n    = n;
    core_base = base;
    ev_seq++;
    ReqValid  = 1'b1;
    ReqTrigId = id;
    req_cyc   = ncyc + 1;
    step();
    ReqValid  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (ReqReady && !OutValid && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk1({name, "_done"}, ok, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    ResetB    = 1'b0;
    ReqValid  = 1'b0;
    ReqTrigId = '0;
    OutReady  = 1'b1;
    CoreData  = '0;
    repeat (3) step();

    // Values held while reset is asserted and just after release.
    chk1("rst_core_read", CoreRead, 1'b0);
    chk1("rst_out_valid", OutValid, 1'b0);
    chk1("rst_busy", Busy, 1'b0);
    chk1("rst_req_ready", ReqReady, 1'b1);
    chkw("rst_trig_id", 64'(CoreTrigIdReq), 64'h0);
    ResetB = 1'b1;
    #2;
    chk1("rel_req_ready", ReqReady, 1'b1);
    chk1("rel_busy", Busy, 1'b0);
    step();

    // Empty event.
    do_req(5'd7, 0, 0);
    wait_done("empty");
    chki("empty_reads", reads_ev, 0);
    chkw("empty_trailer", 64'(seen[seen.size()-1]), 64'h400007);

    // Three hits, with an ignored request while busy.
    do_req(5'd3, 3, 'h11);
    ReqValid  = 1'b1;
    ReqTrigId = 5'd5;
    step();
    ReqValid  = 1'b0;
    wait_done("three");
    chki("three_reads", reads_ev, 3);
    if (read_cyc.size() == 3) begin
      chki("three_first_latency", read_cyc[0] - req_cyc, int'(SETTLE) + 2);
      chki("three_gap1", read_cyc[1] - read_cyc[0], int'(SETTLE) + 3);
      chki("three_gap2", read_cyc[2] - read_cyc[1], int'(SETTLE) + 3);
    end
    chkw("three_w0", 64'(seen[seen.size()-4]), 64'h11);
    chkw("three_w1", 64'(seen[seen.size()-3]), 64'h12);
    chkw("three_w2", 64'(seen[seen.size()-2]), 64'h13);
    chkw("three_trailer", 64'(seen[seen.size()-1]), 64'h400063);

    // Backpressure: one stale trailer plus six hits fill the FIFO to seven.
    OutReady = 1'b0;
    do_req(5'd9, 0, 0);
    do_req(5'd10, 10, 'h200);
    repeat (80) step();
    chki("bp_reads_stalled", reads_ev, 6);
    chk1("bp_out_valid", OutValid, 1'b1);
    chk1("bp_busy", Busy, 1'b1);
    for (int i = 0; i < 60; i++) begin
      OutReady = ((i % 3) != 0);
      step();
    end
    OutReady = 1'b1;
    wait_done("bp");
    chki("bp_reads_total", reads_ev, 10);
    chkw("bp_trailer", 64'(seen[seen.size()-1]), 64'h40014A);

    // Overflow: more hits pending than MAX_HITS.
    do_req(5'd17, 17, 'h300);
    wait_done("ovf");
    chki("ovf_reads", reads_ev, int'(MAX_HITS));
    chkw("ovf_last_hit", 64'(seen[seen.size()-2]), 64'h30B);
    chkw("ovf_trailer", 64'(seen[seen.size()-1]), 64'h402191);

    // Reset while capturing the second hit of an event.
    OutReady = 1'b0;
    do_req(5'd21, 5, 'h400);
    for (int i = 0; i < 100 && reads_ev < 2; i++) step();
    chki("rstmid_reads", reads_ev, 2);
    chk1("rstmid_pre_valid", OutValid, 1'b1);
    ResetB = 1'b0;
    #1;
    chk1("rstmid_core_read", CoreRead, 1'b0);
    chk1("rstmid_out_valid", OutValid, 1'b0);
    chk1("rstmid_busy", Busy, 1'b0);
    chk1("rstmid_req_ready", ReqReady, 1'b1);
    step();
    step();
    ResetB   = 1'b1;
    OutReady = 1'b1;
    do_req(5'd22, 2, 'h500);
    wait_done("after_rst");
    chki("after_rst_reads", reads_ev, 2);
    chkw("after_rst_w0", 64'(seen[seen.size()-3]), 64'h500);
    chkw("after_rst_trailer", 64'(seen[seen.size()-1]), 64'h400056);
    chk1("final_out_valid", OutValid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
